sdram_arbit: RTL

SDRAM_ARBIT -- requirements
Module: sdram_arbit

---
 rtl/sdram_arbit.sv | 119 +++++++++++
 1 files changed

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: the init sequencer owns the bus until init_end,
// then refresh, write and read engines are granted in fixed priority
// (refresh > write > read). A grant runs to completion on its *_end pulse.
module sdram_arbit (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic        init_end,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_sdram_en,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] dq_out,
  output logic        dq_oe
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ARBIT = 5'b00010,
    AREF  = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_t;

  localparam logic [3:0]  NOP_CMD  = 4'b0111;
  localparam logic [1:0]  NOP_BA   = 2'b11;
  localparam logic [12:0] NOP_ADDR = 13'h1fff;

  state_t state_q, state_d;
  logic   aref_en_q, wr_en_q, rd_en_q;
  logic [3:0] cmd;

  // Next-state: fixed priority from ARBIT, no preemption while an engine owns the bus
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init_end) state_d = ARBIT;
      ARBIT: begin
        if (aref_req)     state_d = AREF;
        else if (wr_req)  state_d = WRITE;
        else if (rd_req)  state_d = READ;
      end
      AREF:    if (aref_end) state_d = ARBIT;
      WRITE:   if (wr_end)   state_d = ARBIT;
      READ:    if (rd_end)   state_d = ARBIT;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any transfer and returns to waiting for init
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Grant enables track the state being entered, so they rise with the grant
  // and drop on the edge that samples the matching end pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      aref_en_q <= (state_d == AREF);
      wr_en_q   <= (state_d == WRITE);
      rd_en_q   <= (state_d == READ);
    end
  end

  assign aref_en = aref_en_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;

  // Command bus mux: owner of the current state drives the pins, ARBIT idles with NOP
  always_comb begin
    cmd        = NOP_CMD;
    sdram_ba   = NOP_BA;
    sdram_addr = NOP_ADDR;
    case (state_q)
      IDLE:  begin cmd = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr; end
      AREF:  begin cmd = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr; end
      WRITE: begin cmd = wr_cmd;   sdram_ba = wr_ba;   sdram_addr = wr_addr;   end
      READ:  begin cmd = rd_cmd;   sdram_ba = rd_ba;   sdram_addr = rd_addr;   end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;
  // DQ tristate itself lives at the chip top; only the write engine may drive
  assign dq_out    = wr_data;
  assign dq_oe     = (state_q == WRITE) & wr_sdram_en;

endmodule
